decompress_matrix: RTL and testbench
====================================

Name: decompress_matrix

Overview:
- Receive-side inverse of the 16-channel block-floating-point compressor.
- Takes packets of 16 complex OW-bit mantissas plus one 5-bit block shift per packet, and rebuilds IW-bit sign-extended samples.
- Restores each sample's magnitude by left-shifting it by (IW-OW) − shift.
- Sits before the beamforming/combining stages that consume full-width data. Also checks packet framing and counts packet length.

Parameters:
- IW, 40, output sample width per I/Q component.
- OW, 16, input mantissa width per I/Q component.
- LEN_W, 11, width of the per-packet beat counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- i_sel  in  1  path select, passed through
- i_sop  in  1  start of packet; qualified by i_vld
- i_eop  in  1  end of packet; qualified by i_vld
- i_vld  in  1  input beat valid
- i_din_re  in  16×OW  real mantissas, packed [15:0][OW-1:0]
- i_din_im  in  16×OW  imaginary mantissas
- i_shift  in  5  block shift; sampled only on the i_vld&i_sop beat
- i_slot_idx  in  7 / i_symb_idx  in  4 / i_prb_idx  in  9 / i_ch_type  in  4 / i_info  in  8  packet metadata; sampled on the sop beat
- o_sel, o_sop, o_eop, o_vld  out  1 each  delayed framing
- o_dout_re  out  16×IW  reconstructed real samples
- o_dout_im  out  16×IW  reconstructed imaginary samples
- o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info  out  7/4/9/4/8  metadata held for the packet
- o_blk_len  out  LEN_W  beat count of the packet; valid on the o_eop beat
- o_err_frame  out  1  one-cycle pulse on a framing violation
- o_err_shift  out  1  one-cycle pulse when i_shift > IW-OW

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; counter 0; latched shift 0.
- Fixed latency of 3 clk from an input beat to its output. Sideband, data and error flags stay aligned. There is no backpressure.
- FSM states:
  - IDLE: i_vld&i_sop → PKT; latch shift and metadata; counter = 1.
  - PKT: each i_vld increments the counter. i_vld&i_eop → IDLE.
- Single-beat packet: i_vld&i_sop&i_eop in IDLE is a complete packet with length 1; the FSM stays in IDLE.
- Framing error: i_vld without i_sop while in IDLE.
  - The beat is dropped: o_vld stays 0 for it.
  - o_err_frame pulses, aligned to the dropped beat's output slot.
- Restart: i_vld&i_sop while in PKT.
  - The previous packet is abandoned and o_err_frame pulses.
  - The new packet starts: shift and metadata are re-latched and the counter = 1.
- Gaps: i_vld low inside a packet produces an o_vld bubble. Data out is don't-care when o_vld=0.
- Shift rule: n = (IW-OW) − shift_latched.
  - If i_shift > IW-OW at sop, use n = 0 and pulse o_err_shift once (aligned with that sop output).
  - Shift 31 is treated the same way.
- Arithmetic: dout = sign_extend(din, IW) << n. The n LSBs are zero-filled. The result is exact because OW+n ≤ IW; there is no saturation.
- Pipeline:
  - Stage 1: register inputs and compute n (the sop beat uses i_shift directly).
  - Stage 2: sign-extend and shift.
  - Stage 3: output register.
- Metadata outputs change only on the o_sop beat and hold until the next o_sop.
- o_blk_len counter: saturates at 2^LEN_W−1; it is not a wrap-around counter.
- Reset during a packet: the FSM returns to IDLE and the pipeline is flushed. No o_eop or error pulse is issued for the in-flight packet.

Optional Feature:
- Macro: DECOMP_ROUND_EN.
- When defined and n>0, bit n−1 of each output is set to 1, i.e. dout = (sext(din)<<n) | (1<<(n−1)). This reconstructs the midpoint of the truncation interval. Latency is unchanged.
- When not defined, the low bits are zero-filled.
- With n=0 the output is identical in both builds.

Test Plan:
- Single beat, i_sop=i_eop=1, shift=0, din_re[0]=16'h4000, din_im[0]=16'h8000
  → 3 cycles later o_dout_re[0]=40'h40_0000_0000, o_dout_im[0]=40'h80_0000_0000 (sign-extended), o_blk_len=1.
- 8-beat packet, shift=24, din=16'hFFFF, one-cycle i_vld gap at beat 4
  → every output −1 (40'hFF_FFFF_FFFF); the o_vld bubble appears at the same position; o_blk_len=8 on o_eop; metadata held through the packet.
- Packet with i_shift=30, din=16'h0001
  → o_err_shift pulses with o_sop; output 40'h00_0000_0001 (n=0).
- Stray i_vld in IDLE, then sop in PKT
  → o_err_frame pulses twice; the stray beat gives no o_vld; the second packet's metadata replaces the first at its o_sop.
- DECOMP_ROUND_EN build, shift=23, din=16'h0001
  → output 3; the non-macro build gives 2.
- rst asserted mid-packet, then a new 2-beat packet
  → no output for the aborted packet; the new packet has o_blk_len=2 and no error pulses.

Source files
------------

// File: rtl/decompress_matrix.sv
// Block-floating-point decompressor: 16 complex OW-bit mantissas -> IW-bit samples, 3-clk latency.
// Optional macro DECOMP_ROUND_EN fills bit n-1 with 1 (midpoint reconstruction).
module decompress_matrix #(
  parameter int unsigned IW    = 40,
  parameter int unsigned OW    = 16,
  parameter int unsigned LEN_W = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_sel,
  input  logic                    i_sop,
  input  logic                    i_eop,
  input  logic                    i_vld,
  input  logic [15:0][OW-1:0]     i_din_re,
  input  logic [15:0][OW-1:0]     i_din_im,
  input  logic [4:0]              i_shift,
  input  logic [6:0]              i_slot_idx,
  input  logic [3:0]              i_symb_idx,
  input  logic [8:0]              i_prb_idx,
  input  logic [3:0]              i_ch_type,
  input  logic [7:0]              i_info,
  output logic                    o_sel,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic                    o_vld,
  output logic [15:0][IW-1:0]     o_dout_re,
  output logic [15:0][IW-1:0]     o_dout_im,
  output logic [6:0]              o_slot_idx,
  output logic [3:0]              o_symb_idx,
  output logic [8:0]              o_prb_idx,
  output logic [3:0]              o_type,
  output logic [7:0]              o_info,
  output logic [LEN_W-1:0]        o_blk_len,
  output logic                    o_err_frame,
  output logic                    o_err_shift
);

  localparam int unsigned DIFF = IW - OW;
  localparam int unsigned NW   = $clog2(IW + 1);

  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nx;

  logic             beat_ok, frame_err, start, shift_bad;
  logic [NW-1:0]    n_sop, n_lat, n_use;
  logic [LEN_W-1:0] cnt, cnt_nx;

  // Stage 1
  logic                s1_vld, s1_sop, s1_eop, s1_sel, s1_ef, s1_es;
  logic [NW-1:0]       s1_n;
  logic [15:0][OW-1:0] s1_re, s1_im;
  logic [LEN_W-1:0]    s1_len;
  logic [6:0]          s1_slot;
  logic [3:0]          s1_symb, s1_type;
  logic [8:0]          s1_prb;
  logic [7:0]          s1_info;

  // Stage 2
  logic                s2_vld, s2_sop, s2_eop, s2_sel, s2_ef, s2_es;
  logic [15:0][IW-1:0] shf_re, shf_im, s2_re, s2_im;
  logic [IW-1:0]       rnd;
  logic [LEN_W-1:0]    s2_len;
  logic [6:0]          s2_slot;
  logic [3:0]          s2_symb, s2_type;
  logic [8:0]          s2_prb;
  logic [7:0]          s2_info;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_vld && i_sop && !i_eop) state_nx = PKT;
      PKT:  if (i_vld && i_eop)           state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start     = i_vld && i_sop;
    beat_ok   = i_vld && (i_sop || state == PKT);
    frame_err = i_vld && ((state == IDLE) ? !i_sop : i_sop);
  end

  always_comb begin
    shift_bad = 32'(i_shift) > DIFF;
    n_sop     = shift_bad ? '0 : NW'(DIFF - 32'(i_shift));
    n_use     = start ? n_sop : n_lat;
    if (start)
      cnt_nx = LEN_W'(1);
    else if (beat_ok)
      cnt_nx = (cnt == '1) ? cnt : cnt + LEN_W'(1);
    else
      cnt_nx = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat  <= '0;
      cnt    <= '0;
      s1_vld <= 1'b0; s1_sop <= 1'b0; s1_eop <= 1'b0; s1_sel <= 1'b0;
      s1_ef  <= 1'b0; s1_es  <= 1'b0; s1_n   <= '0;
      s1_re  <= '0;   s1_im  <= '0;   s1_len <= '0;
      s1_slot <= '0; s1_symb <= '0; s1_prb <= '0; s1_type <= '0; s1_info <= '0;
    end else begin
      if (start) begin
        n_lat   <= n_sop;
        s1_slot <= i_slot_idx;
        s1_symb <= i_symb_idx;
        s1_prb  <= i_prb_idx;
        s1_type <= i_ch_type;
        s1_info <= i_info;
      end
      cnt    <= cnt_nx;
      s1_vld <= beat_ok;
      s1_sop <= start;
      s1_eop <= beat_ok && i_eop;
      s1_sel <= i_sel;
      s1_ef  <= frame_err;
      s1_es  <= start && shift_bad;
      s1_n   <= n_use;
      s1_re  <= i_din_re;
      s1_im  <= i_din_im;
      s1_len <= cnt_nx;
    end
  end

  always_comb begin
`ifdef DECOMP_ROUND_EN
    rnd = (s1_n != '0) ? (IW'(1) << (s1_n - NW'(1))) : '0;
`else
    rnd = '0;
`endif
    shf_re = '0;
    shf_im = '0;
    for (int unsigned c = 0; c < 16; c++) begin
      shf_re[c] = ({{DIFF{s1_re[c][OW-1]}}, s1_re[c]} << s1_n) | rnd;
      shf_im[c] = ({{DIFF{s1_im[c][OW-1]}}, s1_im[c]} << s1_n) | rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0; s2_sop <= 1'b0; s2_eop <= 1'b0; s2_sel <= 1'b0;
      s2_ef  <= 1'b0; s2_es  <= 1'b0;
      s2_re  <= '0;   s2_im  <= '0;   s2_len <= '0;
      s2_slot <= '0; s2_symb <= '0; s2_prb <= '0; s2_type <= '0; s2_info <= '0;
    end else begin
      s2_vld  <= s1_vld;  s2_sop  <= s1_sop;  s2_eop  <= s1_eop;  s2_sel <= s1_sel;
      s2_ef   <= s1_ef;   s2_es   <= s1_es;
      s2_re   <= shf_re;  s2_im   <= shf_im;  s2_len  <= s1_len;
      s2_slot <= s1_slot; s2_symb <= s1_symb; s2_prb  <= s1_prb;
      s2_type <= s1_type; s2_info <= s1_info;
    end
  end

  // Metadata outputs move only with o_sop so they hold across the whole packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld <= 1'b0; o_sop <= 1'b0; o_eop <= 1'b0; o_sel <= 1'b0;
      o_err_frame <= 1'b0; o_err_shift <= 1'b0;
      o_dout_re <= '0; o_dout_im <= '0; o_blk_len <= '0;
      o_slot_idx <= '0; o_symb_idx <= '0; o_prb_idx <= '0; o_type <= '0; o_info <= '0;
    end else begin
      o_vld       <= s2_vld;
      o_sop       <= s2_sop;
      o_eop       <= s2_eop;
      o_sel       <= s2_sel;
      o_err_frame <= s2_ef;
      o_err_shift <= s2_es;
      o_dout_re   <= s2_re;
      o_dout_im   <= s2_im;
      o_blk_len   <= s2_len;
      if (s2_sop) begin
        o_slot_idx <= s2_slot;
        o_symb_idx <= s2_symb;
        o_prb_idx  <= s2_prb;
        o_type     <= s2_type;
        o_info     <= s2_info;
      end
    end
  end

endmodule

// File: tb/tb_decompress_matrix.sv
// Directed table-driven bench for decompress_matrix plus saturation and mid-packet reset sequences.
module tb_decompress_matrix;

  localparam int unsigned IW = 40, OW = 16, LEN_W = 11;
`ifdef DECOMP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic i_sel = 0, i_sop = 0, i_eop = 0, i_vld = 0;
  logic [15:0][OW-1:0] i_din_re = '0, i_din_im = '0;
  logic [4:0] i_shift = '0;
  logic [6:0] i_slot_idx = '0;
  logic [3:0] i_symb_idx = '0, i_ch_type = '0;
  logic [8:0] i_prb_idx = '0;
  logic [7:0] i_info = '0;
  logic o_sel, o_sop, o_eop, o_vld, o_err_frame, o_err_shift;
  logic [15:0][IW-1:0] o_dout_re, o_dout_im;
  logic [6:0] o_slot_idx;
  logic [3:0] o_symb_idx, o_type;
  logic [8:0] o_prb_idx;
  logic [7:0] o_info;
  logic [LEN_W-1:0] o_blk_len;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  decompress_matrix #(.IW(IW), .OW(OW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_sel(i_sel), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im), .i_shift(i_shift),
    .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx), .i_prb_idx(i_prb_idx),
    .i_ch_type(i_ch_type), .i_info(i_info),
    .o_sel(o_sel), .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld),
    .o_dout_re(o_dout_re), .o_dout_im(o_dout_im),
    .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx),
    .o_type(o_type), .o_info(o_info), .o_blk_len(o_blk_len),
    .o_err_frame(o_err_frame), .o_err_shift(o_err_shift)
  );

  typedef struct {
    logic v, s, e;
    logic [4:0] sh;
    logic [15:0] re, im;
    logic [6:0] slot;
    logic ev, es, ee;
    logic [39:0] xre, xim;
    logic [10:0] xlen;
    logic xef, xes;
    logic [6:0] xslot;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, s, e, input logic [4:0] sh, input logic [15:0] re, im,
                     input logic [6:0] slot, input logic ev, es, ee,
                     input logic [39:0] xre, xim, input logic [10:0] xlen,
                     input logic xef, xes, input logic [6:0] xslot);
    vec_t t;
    t = '{v, s, e, sh, re, im, slot, ev, es, ee, xre, xim, xlen, xef, xes, xslot};
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, s, e, input logic [4:0] sh, input logic [15:0] re, im,
                       input logic [6:0] slot, input logic sel);
    i_vld = v; i_sop = s; i_eop = e; i_shift = sh; i_sel = sel;
    for (int c = 0; c < 16; c++) begin
      i_din_re[c] = re;
      i_din_im[c] = im;
    end
    i_slot_idx = slot; i_symb_idx = slot[3:0]; i_prb_idx = {2'b0, slot};
    i_ch_type = slot[3:0]; i_info = {1'b0, slot};
  endtask

  task automatic step(input logic v, s, e);
    drive(v, s, e, 5'd24, 16'h0007, 16'h0007, 7'd33, 1'b0);
    @(posedge clk); #1;
  endtask

  localparam logic [39:0] M1 = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] H  = 40'h00_0000_1234;

  initial begin
    vec_t t;
    logic [39:0] r1re, r1im, r8, r23;
    r1re = 40'h40_0000_0000 | (RND ? 40'h00_0080_0000 : 40'h0);
    r1im = 40'h80_0000_0000 | (RND ? 40'h00_0080_0000 : 40'h0);
    r8   = 40'hFF_F00F_0000 | (RND ? 40'h00_0000_8000 : 40'h0);
    r23  = RND ? 40'd3 : 40'd2;

    add(1,1,1, 0,16'h4000,16'h8000, 5, 1,1,1, r1re,r1im, 1, 0,0, 5);
    add(0,0,0, 0,16'h0,16'h0, 0,       0,0,0, 0,0, 0, 0,0, 5);
    add(1,1,0,24,16'hFFFF,16'hFFFF, 9, 1,1,0, M1,M1, 1, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 2, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 3, 0,0, 9);
    add(0,0,0, 5,16'hFFFF,16'hFFFF, 3, 0,0,0, M1,M1, 0, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 4, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 5, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 6, 0,0, 9);
    add(1,0,0, 5,16'hFFFF,16'hFFFF, 3, 1,0,0, M1,M1, 7, 0,0, 9);
    add(1,0,1, 5,16'hFFFF,16'hFFFF, 3, 1,0,1, M1,M1, 8, 0,0, 9);
    add(0,0,0, 0,16'h0,16'h0, 0,       0,0,0, 0,0, 0, 0,0, 9);
    add(1,1,1,30,16'h0001,16'h0001, 2, 1,1,1, 40'd1,40'd1, 1, 0,1, 2);
    add(1,1,1,31,16'h8000,16'h8000, 4, 1,1,1, 40'hFF_FFFF_8000,40'hFF_FFFF_8000, 1, 0,1, 4);
    add(1,0,0, 0,16'h0,16'h0, 7,       0,0,0, 0,0, 0, 1,0, 4);
    add(1,1,0,24,16'h1234,16'h1234,11, 1,1,0, H,H, 1, 0,0, 11);
    add(1,1,0,24,16'h1234,16'h1234,12, 1,1,0, H,H, 1, 1,0, 12);
    add(1,0,1, 3,16'h1234,16'h1234,13, 1,0,1, H,H, 2, 0,0, 12);
    add(1,0,1, 0,16'h0,16'h0, 14,      0,0,0, 0,0, 0, 1,0, 12);
    add(1,1,1, 8,16'hF00F,16'hF00F,20, 1,1,1, r8,r8, 1, 0,0, 20);
    add(1,1,1,23,16'h0001,16'h0001,21, 1,1,1, r23,r23, 1, 0,0, 21);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_sop", o_sop, 0);
    chk("rst_dout", o_dout_re[0], 0);
    chk("rst_len", o_blk_len, 0);
    chk("rst_err", {o_err_frame, o_err_shift}, 0);
    chk("rst_slot", o_slot_idx, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size() + 2; i++) begin
      if (i < tbl.size()) begin
        t = tbl[i];
        drive(t.v, t.s, t.e, t.sh, t.re, t.im, t.slot, i[0]);
      end else
        drive(0, 0, 0, 0, 16'h0, 16'h0, 7'd0, i[0]);
      @(posedge clk); #1;
      if (i >= 2) begin
        automatic int k = i - 2;
        t = tbl[k];
        chk($sformatf("v%0d_vld", k), o_vld, t.ev);
        chk($sformatf("v%0d_sel", k), o_sel, k % 2);
        chk($sformatf("v%0d_eframe", k), o_err_frame, t.xef);
        chk($sformatf("v%0d_eshift", k), o_err_shift, t.xes);
        if (t.ev) begin
          chk($sformatf("v%0d_sop", k), o_sop, t.es);
          chk($sformatf("v%0d_eop", k), o_eop, t.ee);
          chk($sformatf("v%0d_re0", k), o_dout_re[0], t.xre);
          chk($sformatf("v%0d_re15", k), o_dout_re[15], t.xre);
          chk($sformatf("v%0d_im0", k), o_dout_im[0], t.xim);
          chk($sformatf("v%0d_im15", k), o_dout_im[15], t.xim);
          chk($sformatf("v%0d_slot", k), o_slot_idx, t.xslot);
          chk($sformatf("v%0d_info", k), o_info, {1'b0, t.xslot});
          if (t.ee) chk($sformatf("v%0d_len", k), o_blk_len, t.xlen);
        end
      end
    end

    // Length counter saturation over a long packet
    step(1, 1, 0);
    for (int j = 0; j < 2099; j++) step(1, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("sat_eop", o_eop, 1);
    chk("sat_len", o_blk_len, 11'd2047);
    chk("sat_err", {o_err_frame, o_err_shift}, 0);
    step(0, 0, 0);

    // Reset in the middle of a packet, then a clean 2-beat packet
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b1;
    step(1, 0, 0);
    rst = 1'b0;
    chk("rstp_vld0", o_vld, 0);
    step(1, 1, 0);
    chk("rstp_vld1", o_vld, 0);
    chk("rstp_err1", {o_err_frame, o_err_shift}, 0);
    step(1, 0, 1);
    chk("rstp_vld2", o_vld, 0);
    chk("rstp_eop2", o_eop, 0);
    step(0, 0, 0);
    chk("rstp_sop", {o_vld, o_sop}, 2'b11);
    chk("rstp_err3", {o_err_frame, o_err_shift}, 0);
    chk("rstp_slot", o_slot_idx, 33);
    step(0, 0, 0);
    chk("rstp_eop", {o_vld, o_eop}, 2'b11);
    chk("rstp_len", o_blk_len, 2);
    chk("rstp_err4", {o_err_frame, o_err_shift}, 0);
    step(0, 0, 0);
    chk("rstp_idle", o_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
